dc_motor_encoder_reader: RTL and testbench

Quadrature encoder reader for the balance-car DC motors: the feedback half of the motor PWM driver. Synchronises and filters the encoder A/B phases, decodes x4 quadrature into a signed 32-bit position, and measures signed speed as counts per fixed sample window. One instance per motor, attached to the same Avalon-MM fabric as the PWM driver, with the same 2-bit register map style.

---
 rtl/dc_motor_encoder_reader_pkg.sv | 37 +++
 rtl/dc_motor_encoder_reader_phase_filter.sv | 43 ++++
 rtl/dc_motor_encoder_reader.sv | 126 ++++++++++++
 tb/tb_dc_motor_encoder_reader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_motor_encoder_reader_pkg.sv
// Register map and defaults shared by the motor PWM driver and the encoder reader.
// Both blocks use the same 2-bit Avalon-MM register index style.
package dc_motor_encoder_reader_pkg;

    // Encoder reader registers
    localparam logic [1:0] REG_POSITION = 2'd0;
    localparam logic [1:0] REG_SPEED    = 2'd1;
    localparam logic [1:0] REG_CONTROL  = 2'd2;
    localparam logic [1:0] REG_STATUS   = 2'd3;

    // PWM driver registers
    localparam logic [1:0] PWM_REG_PERIOD  = 2'd0;
    localparam logic [1:0] PWM_REG_DUTY    = 2'd1;
    localparam logic [1:0] PWM_REG_CONTROL = 2'd2;
    localparam logic [1:0] PWM_REG_STATUS  = 2'd3;

    localparam int CTRL_ENABLE  = 0;
    localparam int CTRL_DIR_INV = 1;
    localparam int CTRL_POS_CLR = 2;

    localparam int STAT_ERR   = 0;
    localparam int STAT_VALID = 1;

    localparam int DEF_FILTER_LEN    = 4;
    localparam int DEF_SAMPLE_CYCLES = 500000;

    typedef struct packed {
        logic dir_inv;
        logic enable;
    } ctrl_t;

    typedef struct packed {
        logic valid;
        logic err;
    } status_t;

endpackage

// File: rtl/dc_motor_encoder_reader_phase_filter.sv
// One encoder phase: 2-FF synchroniser followed by a FILTER_LEN run-length level filter.
module encoder_phase_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    output logic level_o
);
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q counts the current run of samples that disagree with the accepted level
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == LAST) level_d = sync2_q;
            else               cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/dc_motor_encoder_reader.sv
// x4 quadrature decoder with signed position, windowed speed and an Avalon-MM register file.
module dc_motor_encoder_reader
    import dc_motor_encoder_reader_pkg::*;
#(
    parameter int FILTER_LEN    = DEF_FILTER_LEN,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_cs,
    input  logic [1:0]  s_address,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    input  logic        s_read,
    output logic [31:0] s_readdata,
    input  logic        ENC_A,
    input  logic        ENC_B,
    output logic        speed_valid
);
    localparam int WW = $clog2(SAMPLE_CYCLES);
    localparam logic [WW-1:0] WIN_LAST = WW'(SAMPLE_CYCLES - 1);

    logic          filt_a, filt_b;
    logic [1:0]    ab_cur, ab_prev_q;
    logic [31:0]   raw_step, step;
    logic          illegal, wr, rd, tc;
    logic [31:0]   pos_q, pos_d, speed_q, speed_d, acc_q, acc_d, rdata_q, rdata_d;
    logic [WW-1:0] win_q, win_d;
    ctrl_t         ctrl_q, ctrl_d;
    status_t       stat_q, stat_d;
    logic [1:0]    stat_clr;
    logic          svld_q;

    encoder_phase_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk(clk), .reset_n(reset_n), .raw_i(ENC_A), .level_o(filt_a)
    );
    encoder_phase_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk(clk), .reset_n(reset_n), .raw_i(ENC_B), .level_o(filt_b)
    );

    assign ab_cur = {filt_a, filt_b};

    // Gray sequence 00->01->11->10->00 is forward
    always_comb begin
        raw_step = '0;
        illegal  = 1'b0;
        case ({ab_prev_q, ab_cur})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: raw_step = 32'd1;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: raw_step = '1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal  = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        wr       = s_cs & s_write;
        rd       = s_cs & s_read & ~s_write;
        step     = ctrl_q.enable ? (ctrl_q.dir_inv ? -raw_step : raw_step) : '0;
        tc       = ctrl_q.enable && (win_q == WIN_LAST);
        stat_clr = (wr && s_address == REG_STATUS) ? s_writedata[1:0] : 2'b00;

        pos_d = pos_q + step;
        if (wr && s_address == REG_POSITION)
            pos_d = s_writedata;
        else if (wr && s_address == REG_CONTROL && s_writedata[CTRL_POS_CLR])
            pos_d = '0;

        ctrl_d = ctrl_q;
        if (wr && s_address == REG_CONTROL)
            ctrl_d = ctrl_t'(s_writedata[1:0]);

        // The speed window still counts a step that a POSITION write overrode
        speed_d = speed_q;
        acc_d   = '0;
        win_d   = '0;
        if (ctrl_q.enable) begin
            if (tc) begin
                speed_d = acc_q + step;
            end else begin
                acc_d = acc_q + step;
                win_d = win_q + WW'(1);
            end
        end

        stat_d.err   = (stat_q.err   & ~stat_clr[STAT_ERR])   | illegal;
        stat_d.valid = (stat_q.valid & ~stat_clr[STAT_VALID]) | tc;

        rdata_d = rdata_q;
        if (rd) begin
            case (s_address)
                REG_POSITION: rdata_d = pos_q;
                REG_SPEED:    rdata_d = speed_q;
                REG_CONTROL:  rdata_d = {30'b0, ctrl_q};
                default:      rdata_d = {30'b0, stat_q};
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ab_prev_q <= 2'b00;
            pos_q     <= '0;
            speed_q   <= '0;
            acc_q     <= '0;
            win_q     <= '0;
            ctrl_q    <= '0;
            stat_q    <= '0;
            rdata_q   <= '0;
            svld_q    <= 1'b0;
        end else begin
            ab_prev_q <= ab_cur;
            pos_q     <= pos_d;
            speed_q   <= speed_d;
            acc_q     <= acc_d;
            win_q     <= win_d;
            ctrl_q    <= ctrl_d;
            stat_q    <= stat_d;
            rdata_q   <= rdata_d;
            svld_q    <= tc;
        end
    end

    assign s_readdata  = rdata_q;
    assign speed_valid = svld_q;

endmodule

// File: tb/tb_dc_motor_encoder_reader.sv
// Randomised and directed bench for the encoder reader, checked every cycle against a behavioural model.
module tb_dc_motor_encoder_reader;
    localparam int FL = 4;
    localparam int SC = 1000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_cs = 1'b0, s_write = 1'b0, s_read = 1'b0;
    logic [1:0]  s_address = 2'd0;
    logic [31:0] s_writedata = 32'd0;
    logic [31:0] s_readdata;
    logic        ENC_A = 1'b0, ENC_B = 1'b0;
    logic        speed_valid;

    int vectors = 0, miscompares = 0;

    dc_motor_encoder_reader #(.FILTER_LEN(FL), .SAMPLE_CYCLES(SC)) dut (
        .clk(clk), .reset_n(reset_n), .s_cs(s_cs), .s_address(s_address),
        .s_write(s_write), .s_writedata(s_writedata), .s_read(s_read),
        .s_readdata(s_readdata), .ENC_A(ENC_A), .ENC_B(ENC_B), .speed_valid(speed_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          gidx [4] = '{0, 1, 3, 2};   // position of {A,B} in the Gray cycle
    bit          m_s1a, m_s2a, m_s1b, m_s2b, m_fa, m_fb, m_pa, m_pb;
    bit          hist_a[$], hist_b[$];
    logic [31:0] m_pos, m_speed, m_rdata;
    int          m_acc, m_win;
    bit          m_en, m_inv, m_err, m_val, m_sv;
    int          cyc = 0;

    function automatic bit run_of(input bit q[$], input bit v);
        if (q.size() < FL) return 1'b0;
        for (int i = q.size() - FL; i < q.size(); i++) if (q[i] != v) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_reg(input logic [1:0] a);
        case (a)
            2'd0: return m_pos;
            2'd1: return m_speed;
            2'd2: return {30'b0, m_inv, m_en};
            default: return {30'b0, m_val, m_err};
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {m_s1a, m_s2a, m_s1b, m_s2b, m_fa, m_fb, m_pa, m_pb} = '0;
            hist_a.delete(); hist_b.delete();
            m_pos = 0; m_speed = 0; m_rdata = 0; m_acc = 0; m_win = 0;
            {m_en, m_inv, m_err, m_val, m_sv} = '0;
            #1;
            chk("reset_readdata", s_readdata, 32'd0);
            chk("reset_speed_valid", {31'b0, speed_valid}, 32'd0);
        end else begin
            int  d, raw, stp;
            bit  wr, rd, ill, tc;
            cyc++;
            d   = (gidx[{m_fa, m_fb}] - gidx[{m_pa, m_pb}] + 4) % 4;
            raw = (d == 1) ? 1 : (d == 3) ? -1 : 0;
            ill = (d == 2);
            stp = m_en ? (m_inv ? -raw : raw) : 0;
            wr  = s_cs && s_write;
            rd  = s_cs && s_read && !s_write;
            tc  = m_en && (m_win == SC - 1);
            if (rd) m_rdata = m_reg(s_address);

            if (wr && s_address == 2'd0)                     m_pos = s_writedata;
            else if (wr && s_address == 2'd2 && s_writedata[2]) m_pos = 0;
            else                                             m_pos = m_pos + 32'(stp);

            if (!m_en)   begin m_win = 0; m_acc = 0; end
            else if (tc) begin m_speed = 32'(m_acc + stp); m_acc = 0; m_win = 0; end
            else         begin m_win++; m_acc += stp; end

            if (wr && s_address == 2'd3) begin
                if (s_writedata[0]) m_err = 0;
                if (s_writedata[1]) m_val = 0;
            end
            if (ill) m_err = 1;
            if (tc)  m_val = 1;
            if (wr && s_address == 2'd2) begin m_en = s_writedata[0]; m_inv = s_writedata[1]; end
            m_sv = tc;

            m_pa = m_fa; m_pb = m_fb;
            hist_a.push_back(m_s2a); if (hist_a.size() > FL) void'(hist_a.pop_front());
            hist_b.push_back(m_s2b); if (hist_b.size() > FL) void'(hist_b.pop_front());
            if (run_of(hist_a, !m_fa)) m_fa = !m_fa;
            if (run_of(hist_b, !m_fb)) m_fb = !m_fb;
            m_s2a = m_s1a; m_s1a = ENC_A;
            m_s2b = m_s1b; m_s1b = ENC_B;
            #1;
            chk("readdata", s_readdata, m_rdata);
            chk("speed_valid", {31'b0, speed_valid}, {31'b0, m_sv});
        end
    end

    // Interval between DUT speed_valid pulses, in cycles
    int pulse_cyc = 0, last_int = 0;
    always @(posedge clk) begin
        #1;
        if (reset_n && speed_valid) begin
            last_int  = cyc - pulse_cyc;
            pulse_cyc = cyc;
        end
    end

    // ---------------- stimulus ----------------
    int g = 0;

    task automatic drive_enc();
        {ENC_A, ENC_B} = 2'(g ^ (g >> 1));
    endtask

    task automatic steps(input int n, input int dir, input int hold);
        repeat (n) begin
            @(negedge clk); g = (g + dir) & 3; drive_enc();
            repeat (hold - 1) @(negedge clk);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk); s_cs = 1; s_write = 1; s_address = a; s_writedata = d;
        @(negedge clk); s_cs = 0; s_write = 0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk); s_cs = 1; s_read = 1; s_address = a;
        @(negedge clk); s_cs = 0; s_read = 0; d = s_readdata;
    endtask

    task automatic expect_reg(input string nm, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        chk(nm, d, exp);
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w;
        settle(3);
        reset_n = 1;
        settle(2);
        for (int a = 0; a < 4; a++) expect_reg("reset_reg", 2'(a), 32'd0);

        bus_write(2'd2, 32'h1);
        steps(32, 1, 10); settle(12);
        expect_reg("fwd_pos", 2'd0, 32'd32);
        bus_write(2'd2, 32'h7);
        steps(32, 1, 10); settle(12);
        expect_reg("inv_pos", 2'd0, 32'hFFFF_FFE0);
        bus_write(2'd2, 32'h5);
        expect_reg("ctrl_clr_pos", 2'd0, 32'd0);
        expect_reg("ctrl_rd", 2'd2, 32'h1);
        steps(32, -1, 10); settle(12);
        expect_reg("rev_pos", 2'd0, 32'hFFFF_FFE0);

        // Glitch and illegal jump with counting disabled so STATUS.valid stays clear
        bus_write(2'd2, 32'h0);
        bus_write(2'd3, 32'h3);
        @(negedge clk); ENC_A = ~ENC_A; settle(3); ENC_A = ~ENC_A; settle(12);
        expect_reg("glitch_pos", 2'd0, 32'hFFFF_FFE0);
        expect_reg("glitch_status", 2'd3, 32'h0);
        @(negedge clk); g = 2; drive_enc(); settle(10);
        expect_reg("illegal_pos", 2'd0, 32'hFFFF_FFE0);
        expect_reg("illegal_status", 2'd3, 32'h1);
        bus_write(2'd3, 32'h1);
        expect_reg("status_w1c", 2'd3, 32'h0);

        // Speed: one step every 50 cycles over 3000 cycles
        bus_write(2'd2, 32'h1);
        steps(60, 1, 50);
        expect_reg("speed_20", 2'd1, 32'd20);
        chk("pulse_interval", 32'(last_int), 32'd1000);
        bus_write(2'd2, 32'h0);
        expect_reg("speed_hold_a", 2'd1, 32'd20);
        settle(300);
        expect_reg("speed_hold_b", 2'd1, 32'd20);
        bus_write(2'd2, 32'h1);
        w = cyc;
        for (int i = 0; i < 1100 && pulse_cyc <= w; i++) @(negedge clk);
        chk("reenable_window", 32'(pulse_cyc - w), 32'd1000);

        // Position write / wrap / coincident write
        bus_write(2'd0, 32'h7FFF_FFFF);
        steps(1, 1, 10); settle(10);
        expect_reg("wrap_pos", 2'd0, 32'h8000_0000);
        @(negedge clk); g = (g + 1) & 3; drive_enc();
        settle(6);
        s_cs = 1; s_write = 1; s_address = 2'd0; s_writedata = 32'd5;
        @(negedge clk); s_cs = 0; s_write = 0;
        settle(12);
        expect_reg("write_wins", 2'd0, 32'd5);
        bus_write(2'd2, 32'h5);
        expect_reg("clr_pos", 2'd0, 32'd0);
        expect_reg("clr_ctrl", 2'd2, 32'h1);

        // Async reset in the middle of a window
        steps(5, 1, 10); settle(12);
        expect_reg("pre_reset_pos", 2'd0, 32'd5);
        @(negedge clk); #3; reset_n = 0; g = 0; drive_enc();
        #1;
        chk("async_rdata", s_readdata, 32'd0);
        settle(3);
        reset_n = 1;
        settle(2);
        for (int a = 0; a < 4; a++) expect_reg("post_reset_reg", 2'(a), 32'd0);
        bus_write(2'd2, 32'h1);
        steps(4, 1, 10); settle(12);
        expect_reg("resume_pos", 2'd0, 32'd4);

        // Random traffic
        for (int it = 0; it < 200; it++) begin
            int r;
            logic [31:0] d;
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                int dir;
                dir = ($urandom_range(0, 7) == 0) ? 2 : (($urandom_range(0, 1) == 1) ? 1 : -1);
                steps(1, dir, $urandom_range(1, 12));
            end else if (r == 6) begin
                bus_write(2'($urandom_range(0, 3)), $urandom);
            end else if (r == 7) begin
                bus_read(2'($urandom_range(0, 3)), d);
            end else if (r == 8) begin
                @(negedge clk); s_cs = 1; s_read = 1; s_write = 1;
                s_address = 2'($urandom_range(0, 3)); s_writedata = $urandom;
                @(negedge clk); s_cs = 0; s_read = 0; s_write = 0;
            end else begin
                bus_write(2'd3, 32'h3);
            end
        end
        settle(20);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
